// File: rtl/gpu_protocol_pkg.sv
// Shared GPU command-path protocol constants and types.
// Used by the command sender, UART peers and the instruction engine.
package gpu_protocol_pkg;

  localparam logic [7:0] OPCODE_WRITE_PIXEL = 8'hA5;
  localparam int PACKET_BYTES = 5;

  localparam int RESOLUTION_W = 640;
  localparam int RESOLUTION_H = 480;
  localparam int FRAMEBUFFER_DEPTH = RESOLUTION_W * RESOLUTION_H;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_LOAD,
    SND_SEND,
    SND_FINISH
  } sender_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_e;

  function automatic logic [7:0] packet_byte(
    input logic [2:0]  idx,
    input logic [23:0] addr,
    input logic [7:0]  data
  );
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = OPCODE_WRITE_PIXEL;
      3'd1:    b = addr[23:16];
      3'd2:    b = addr[15:8];
      3'd3:    b = addr[7:0];
      default: b = data;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, peer of uart_receiver.
// Done marks the final stop-bit cycle so frames can follow with one idle cycle.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);
  import gpu_protocol_pkg::*;

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          serial_n;
  logic          tick;

  assign tick = (baud == LAST);
  assign o_Tx_Done = (state == TX_STOP) && tick;
  assign o_Tx_Active =
    state inside {TX_START, TX_DATA, TX_STOP};

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    serial_n = o_Tx_Serial;
    unique case (state)
      TX_IDLE, TX_CLEANUP: begin
        serial_n = 1'b1;
        state_n  = TX_IDLE;
        if (i_Tx_DV) begin
          state_n  = TX_START;
          serial_n = 1'b0;
          shreg_n  = i_Tx_Byte;
          baud_n   = '0;
          bit_n    = '0;
        end
      end
      TX_START: begin
        if (tick) begin
          baud_n   = '0;
          state_n  = TX_DATA;
          serial_n = shreg[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      TX_DATA: begin
        if (tick) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n  = TX_STOP;
            serial_n = 1'b1;
          end else begin
            bit_n    = bit_idx + 3'd1;
            shreg_n  = {1'b0, shreg[7:1]};
            serial_n = shreg[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      TX_STOP: begin
        if (tick) begin
          baud_n  = '0;
          state_n = TX_CLEANUP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= TX_IDLE;
      baud        <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_n;
      baud        <= baud_n;
      bit_idx     <= bit_n;
      shreg       <= shreg_n;
      o_Tx_Serial <= serial_n;
    end
  end

endmodule

// File: rtl/gpu_command_sender.sv
// Packs pixel-write commands into 5-byte packets and sends them
// over the UART line feeding the GPU receiver.
module gpu_command_sender #(
  parameter int CLOCK_FREQUENCY   = 100_000_000,
  parameter int UART_BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT      = CLOCK_FREQUENCY / UART_BAUD_RATE,
  parameter int BITS_PER_PIXEL    = 4,
  parameter int FRAMEBUFFER_DEPTH = gpu_protocol_pkg::FRAMEBUFFER_DEPTH
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Cmd_Valid,
  output logic                      o_Cmd_Ready,
  input  logic [31:0]               i_Cmd_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Cmd_Data,
  output logic                      o_Uart_Tx,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Error
);
  import gpu_protocol_pkg::*;

  sender_state_e             state, state_n;
  logic [2:0]                idx, idx_n;
  logic [23:0]               addr_q;
  logic [BITS_PER_PIXEL-1:0] data_q;
  logic                      accept, in_range;
  logic                      tx_dv, tx_done, tx_active;
  logic [7:0]                tx_byte;

  assign accept   = i_Cmd_Valid && o_Cmd_Ready;
  assign in_range = i_Cmd_Addr < 32'(FRAMEBUFFER_DEPTH);
  assign tx_byte  = packet_byte(idx, addr_q, 8'(data_q));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tx_dv   = 1'b0;
    unique case (state)
      SND_IDLE: begin
        if (accept && in_range) begin
          state_n = SND_LOAD;
          idx_n   = '0;
        end
      end
      SND_LOAD: begin
        if (!tx_active) begin
          tx_dv   = 1'b1;
          state_n = SND_SEND;
        end
      end
      SND_SEND: begin
        if (tx_done) begin
          if (idx == 3'(PACKET_BYTES - 1)) begin
            state_n = SND_FINISH;
            idx_n   = '0;
          end else begin
            state_n = SND_LOAD;
            idx_n   = idx + 3'd1;
          end
        end
      end
      SND_FINISH: state_n = SND_IDLE;
      default:    state_n = SND_IDLE;
    endcase
  end

  // Status outputs are registered from the next state.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= SND_IDLE;
      idx         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      o_Cmd_Ready <= 1'b1;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        addr_q <= i_Cmd_Addr[23:0];
        data_q <= i_Cmd_Data;
      end
      o_Cmd_Ready <= (state_n == SND_IDLE);
      o_Busy      <= (state_n != SND_IDLE);
      o_Done      <= (state_n == SND_FINISH);
      o_Error     <= accept && !in_range;
    end
  end

  uart_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Tx_DV    (tx_dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Serial(o_Uart_Tx),
    .o_Tx_Active(tx_active),
    .o_Tx_Done  (tx_done)
  );

endmodule

// File: tb/tb_gpu_command_sender.sv
// Scoreboard bench for gpu_command_sender: a UART receiver model
// decodes the line and checks bytes, bit timing, done and error pulses.
module tb_gpu_command_sender;

  localparam int CPB   = 4;
  localparam int BPP   = 4;
  localparam int DEPTH = 640 * 480;
  localparam int FRAME = 10 * CPB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid = 1'b0;
  logic [31:0]    addr = '0;
  logic [BPP-1:0] data = '0;
  logic           ready, tx, busy, done, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_done_cyc = -100;

  logic [7:0] exp_bytes[$];
  int         start_q[$];
  int         done_q[$];
  int         err_q[$];

  gpu_command_sender #(
    .CLKS_PER_BIT  (CPB),
    .BITS_PER_PIXEL(BPP)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Cmd_Valid(valid),
    .o_Cmd_Ready(ready),
    .i_Cmd_Addr (addr),
    .i_Cmd_Data (data),
    .o_Uart_Tx  (tx),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Error    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i,
                                            input longint a,
                                            input int d);
    longint v;
    case (i)
      0:       v = 165;
      1:       v = (a / 65536) % 256;
      2:       v = (a / 256) % 256;
      3:       v = a % 256;
      default: v = d % (1 << BPP);
    endcase
    return 8'(v);
  endfunction

  // Receiver model and pulse scoreboard
  initial begin : monitor
    bit         rx_on;
    int         n, c0, pos, prev_c, exp_start;
    logic [39:0] s;
    logic [7:0] b;
    bit         width_ok;
    rx_on = 0; n = 0; c0 = 0; pos = 0; prev_c = 0; s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_on = 0;
        pos = 0;
        continue;
      end
      if (busy) chk("ready_low_while_busy", ready, 0);
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
        last_done_cyc = cyc;
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_error", 1, 0);
        else chk("error_cycle", cyc, err_q.pop_front());
      end
      if (!rx_on) begin
        if (!tx) begin
          rx_on = 1;
          n = 1;
          s = '0;
          if (pos == 0) begin
            if (start_q.size() == 0) chk("unexpected_frame", 1, 0);
            else begin
              exp_start = start_q.pop_front();
              chk("b0_start_cycle", cyc, exp_start);
              done_q.push_back(exp_start + 50 * CPB + 4);
            end
          end else begin
            chk("byte_gap", cyc, prev_c + FRAME + 1);
          end
          c0 = cyc;
        end
      end else begin
        s[n] = tx;
        n++;
        if (n == FRAME) begin
          rx_on = 0;
          prev_c = c0;
          width_ok = 1;
          b = '0;
          for (int i = 0; i < 10; i++)
            for (int j = 0; j < CPB; j++)
              if (s[i*CPB+j] !== s[i*CPB]) width_ok = 0;
          for (int i = 0; i < 8; i++) b[i] = s[(i+1)*CPB + CPB/2];
          chk("bit_width", width_ok, 1);
          chk("start_bit", s[CPB-1:0], 0);
          chk("stop_bit", s[FRAME-1 -: CPB], (1 << CPB) - 1);
          if (exp_bytes.size() == 0) chk("unexpected_byte", 1, 0);
          else chk($sformatf("byte%0d", pos), b, exp_bytes.pop_front());
          pos = (pos + 1) % 5;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input int d,
                      input bit hold, input bit gap_chk,
                      output int k);
    int w;
    w = 0;
    addr = a;
    data = d[BPP-1:0];
    valid = 1'b1;
    while (!ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("accept_timeout", 0, 1);
      valid = 1'b0;
      k = cyc;
      return;
    end
    k = cyc;
    if (gap_chk) chk("ready_after_done", k, last_done_cyc + 1);
    if (longint'(a) >= DEPTH) err_q.push_back(k + 1);
    else begin
      for (int i = 0; i < 5; i++)
        exp_bytes.push_back(model_byte(i, a, d));
      start_q.push_back(k + 2);
    end
    @(negedge clk);
    if (longint'(a) >= DEPTH) chk("ready_after_error", ready, 1);
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_bytes.size() != 0 || start_q.size() != 0 ||
            done_q.size() != 0 || err_q.size() != 0 || busy)
           && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #(600_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, r, gap;
    logic [31:0] ra;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx, ready, busy, done, err}, 5'b11000);
    rst = 1'b0;

    repeat (100) begin
      @(negedge clk);
      chk("idle_outputs", {tx, ready, busy, done, err}, 5'b11000);
    end

    send(32'h0000_04B0, 7, 0, 0, k);
    drain();

    send(32'd307200, 0, 0, 0, k);
    repeat (2) @(negedge clk);
    send(32'd307199, 15, 0, 0, k);
    drain();

    send(32'h0001_0203, 1, 1, 0, k);
    send(32'h0002_A0B0, 9, 1, 1, k);
    send(32'h0003_FFFE, 6, 1, 1, k);
    valid = 1'b0;
    drain();

    send(32'h0000_1234, 5, 0, 0, k);
    while (cyc < k + 101) @(negedge clk);
    chk("pre_reset_line", tx, 0);
    #1 rst = 1'b1;
    #1 chk("reset_line_async", tx, 1);
    chk("reset_busy_async", busy, 0);
    exp_bytes.delete();
    start_q.delete();
    done_q.delete();
    err_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    send(32'h0000_0155, 32'hA, 0, 0, k);
    drain();

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) ra = 32'(DEPTH) + $urandom_range(0, 1 << 20);
      else if (r == 2) ra = $urandom | 32'h0100_0000;
      else ra = $urandom_range(0, DEPTH - 1);
      send(ra, int'($urandom_range(0, 15)), 0, 0, k);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    drain();
    chk("leftover_bytes", exp_bytes.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
